mux_scan_nx1: RTL and testbench

//  Registered N-channel, WIDTH-bit selector; generalises the 16-bit 2:1 mux to CH inputs.
//  Two modes: manual select on a load strobe, or auto-scan across all channels.

---
 rtl/mux_scan_nx1_pkg.sv | 26 ++
 rtl/mux_scan_nx1_dwell_counter.sv | 44 ++++
 rtl/mux_scan_nx1.sv | 151 +++++++++++++++
 tb/tb_mux_scan_nx1.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_nx1_pkg.sv
// Shared definitions for the mux_scan_nx1 selector.
//   - mode encodings for the mode input (manual vs. scan)
//   - FSM state encoding (2-bit)
//   - clog2_min1(): ceil(log2(n)), never less than 1, used to size index and counter fields
package mux_scan_nx1_pkg;

    localparam logic ModeMan  = 1'b0;
    localparam logic ModeScan = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMan  = 2'b01,
        StScan = 2'b10
    } state_e;

    // A field must be at least one bit wide even when only one value exists.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_scan_nx1_dwell_counter.sv
// Dwell counter for the auto-scan mode of mux_scan_nx1.
// Counts 0 .. DWELL-1 and wraps; tc is high while the count sits at DWELL-1.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset (count -> 0)
//   clr  in   synchronous clear (count -> 0), used on every mode change and while not scanning
//   tc   out  terminal count (count == DWELL-1); constantly 1 when DWELL == 1
module mux_scan_nx1_dwell_counter
    import mux_scan_nx1_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CW = clog2_min1(DWELL);
    localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tc) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered CH-channel, WIDTH-bit selector with manual and auto-scan modes.
//   Manual (mode=0): a load strobe captures in_bus[sel] on the next edge.
//   Scan   (mode=1): captures the next channel on entry, then every DWELL clocks,
//                    wrapping CH-1 -> 0.
// Optional feature: define MUX_PARITY_EN to add out_par (even-parity XOR of the captured data,
// registered alongside out, reset 0). Without the macro the port and its logic are absent.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, wins over every other input
//   in_bus     in   CH*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   sel        in   SW, manual channel index
//   mode       in   0 = manual, 1 = scan
//   load       in   manual capture strobe (ignored in scan)
//   out        out  WIDTH, registered selected data
//   out_valid  out  1-cycle pulse per capture (stays high when capturing every cycle)
//   cur_ch     out  SW, channel index of out
//   sel_err    out  1-cycle pulse when a manual load names a channel >= CH
//   out_par    out  (MUX_PARITY_EN only) XOR reduction of out
module mux_scan_nx1
    import mux_scan_nx1_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CH    = 4,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SW   = clog2_min1(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] in_bus,
    input  logic [SW-1:0]       sel,
    input  logic                mode,
    input  logic                load,
    output logic [WIDTH-1:0]    out,
    output logic                out_valid,
    output logic [SW-1:0]       cur_ch,
    output logic                sel_err
`ifdef MUX_PARITY_EN
    ,
    output logic                out_par
`endif
);

    localparam logic [SW-1:0] LastCh = SW'(CH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    ch_q, ch_d;
    logic             err_q, err_d;

    logic             cap_en;
    logic [SW-1:0]    cap_idx;
    logic [WIDTH-1:0] cap_data;
    logic [SW-1:0]    next_ch;
    logic             sel_ok;
    logic             dwell_clr;
    logic             dwell_tc;

    assign next_ch = (ch_q == LastCh) ? '0 : ch_q + 1'b1;
    assign sel_ok  = (32'(sel) < CH);

    // cap_idx is always a legal channel whenever cap_en is set.
    assign cap_data = in_bus[32'(cap_idx) * WIDTH +: WIDTH];

    mux_scan_nx1_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .tc  (dwell_tc)
    );

    // The mode input decides what happens at each edge; the state only remembers the previous
    // mode so that the first edge of a scan run can be recognised. A mode change together with
    // load therefore acts in the new mode at once.
    always_comb begin
        state_d   = state_q;
        cap_en    = 1'b0;
        cap_idx   = ch_q;
        err_d     = 1'b0;
        dwell_clr = 1'b1;

        if (mode == ModeScan) begin
            state_d = StScan;
            if (state_q != StScan) begin
                // Entry edge: capture the next channel, counter held at 0 by dwell_clr.
                cap_en  = 1'b1;
                cap_idx = next_ch;
            end else begin
                dwell_clr = 1'b0;
                if (dwell_tc) begin
                    cap_en  = 1'b1;
                    cap_idx = next_ch;
                end
            end
        end else begin
            state_d = StMan;
            if (load) begin
                if (sel_ok) begin
                    cap_en  = 1'b1;
                    cap_idx = sel;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_d   = cap_en ? cap_data : out_q;
        ch_d    = cap_en ? cap_idx : ch_q;
        valid_d = cap_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign cur_ch    = ch_q;
    assign sel_err   = err_q;

`ifdef MUX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (cap_en) begin
            par_q <= ^cap_data;
        end
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: instance A (CH=4, DWELL=4) and instance B
// (CH=3, DWELL=1) share control inputs; a behavioural model predicts both every edge.
module tb_mux_scan_nx1;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, mode, load;
    logic [1:0]     sel;
    logic [4*W-1:0] bus_a;
    logic [3*W-1:0] bus_b;
    logic [W-1:0]   out_a, out_b;
    logic           val_a, val_b, err_a, err_b;
    logic [1:0]     ch_a, ch_b;
`ifdef MUX_PARITY_EN
    logic           par_a, par_b;
`endif

    mux_scan_nx1 #(.WIDTH(W), .CH(4), .DWELL(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (bus_a),
        .sel       (sel),
        .mode      (mode),
        .load      (load),
        .out       (out_a),
        .out_valid (val_a),
        .cur_ch    (ch_a),
        .sel_err   (err_a)
`ifdef MUX_PARITY_EN
        ,
        .out_par   (par_a)
`endif
    );

    mux_scan_nx1 #(.WIDTH(W), .CH(3), .DWELL(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (bus_b),
        .sel       (sel),
        .mode      (mode),
        .load      (load),
        .out       (out_b),
        .out_valid (val_b),
        .cur_ch    (ch_b),
        .sel_err   (err_b)
`ifdef MUX_PARITY_EN
        ,
        .out_par   (par_b)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic set_a(input int k, input int v);
        bus_a[k*W +: W] = v[W-1:0];
    endtask

    task automatic set_b(input int k, input int v);
        bus_b[k*W +: W] = v[W-1:0];
    endtask

    function automatic int chan(input int d, input int k);
        if (d == 0) return int'(bus_a[k*W +: W]);
        return int'(bus_b[k*W +: W]);
    endfunction

    // Model state: m_prev = -1 after reset, 0 manual, 1 scan; m_age = edges since last scan capture.
    int m_out[2], m_ch[2], m_valid[2], m_err[2], m_par[2], m_prev[2], m_age[2];

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int nch;
            int dw;
            nch = (d == 0) ? 4 : 3;
            dw  = (d == 0) ? 4 : 1;
            m_valid[d] = 0;
            m_err[d]   = 0;
            if (rst) begin
                m_out[d] = 0; m_ch[d] = 0; m_prev[d] = -1; m_age[d] = 0;
            end else if (!mode) begin
                if (load) begin
                    if (int'(sel) < nch) begin
                        m_ch[d] = int'(sel); m_out[d] = chan(d, int'(sel)); m_valid[d] = 1;
                    end else begin
                        m_err[d] = 1;
                    end
                end
                m_prev[d] = 0; m_age[d] = 0;
            end else begin
                if (m_prev[d] != 1 || m_age[d] + 1 >= dw) begin
                    m_ch[d] = (m_ch[d] + 1) % nch;
                    m_out[d] = chan(d, m_ch[d]);
                    m_valid[d] = 1; m_age[d] = 0;
                end else begin
                    m_age[d]++;
                end
                m_prev[d] = 1;
            end
            m_par[d] = $countones(m_out[d]) % 2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("a.out", int'(out_a), m_out[0]);
        check("a.valid", int'(val_a), m_valid[0]);
        check("a.cur_ch", int'(ch_a), m_ch[0]);
        check("a.sel_err", int'(err_a), m_err[0]);
        check("b.out", int'(out_b), m_out[1]);
        check("b.valid", int'(val_b), m_valid[1]);
        check("b.cur_ch", int'(ch_b), m_ch[1]);
        check("b.sel_err", int'(err_b), m_err[1]);
`ifdef MUX_PARITY_EN
        check("a.out_par", int'(par_a), m_par[0]);
        check("b.out_par", int'(par_b), m_par[1]);
`endif
    endtask

    typedef struct {
        logic       mode;
        logic       load;
        logic [1:0] sel;
        int         out;
        int         valid;
        int         ch;
        int         err;
    } vec_t;

    vec_t vecs[7];
    int   t3_exp[4];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd1, 12512, 1, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 12512, 0, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 15163, 1, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 2'd2, 15163, 0, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 2'd3, 3865,  1, 3, 0};
        vecs[5] = '{1'b0, 1'b1, 2'd2, 8254,  1, 2, 0};
        vecs[6] = '{1'b0, 1'b0, 2'd0, 8254,  0, 2, 0};
        t3_exp[0] = 7224; t3_exp[1] = 275; t3_exp[2] = 3865; t3_exp[3] = 235;

        rst = 1'b1; mode = 1'b0; load = 1'b0; sel = 2'd0;
        bus_a = '0; bus_b = '0;
        set_a(0, 15163); set_a(1, 12512); set_a(2, 8254); set_a(3, 3865);
        set_b(0, 1111); set_b(1, 2222); set_b(2, 3333);

        // Reset state
        step(); step();
        check("reset.out", int'(out_a), 0);
        check("reset.valid", int'(val_a), 0);
        check("reset.cur_ch", int'(ch_a), 0);
        check("reset.sel_err", int'(err_a), 0);
        rst = 1'b0;

        // Manual captures from the table
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode; load = vecs[i].load; sel = vecs[i].sel;
            step();
            check($sformatf("vec%0d.out", i), int'(out_a), vecs[i].out);
            check($sformatf("vec%0d.valid", i), int'(val_a), vecs[i].valid);
            check($sformatf("vec%0d.cur_ch", i), int'(ch_a), vecs[i].ch);
            check($sformatf("vec%0d.sel_err", i), int'(err_a), vecs[i].err);
        end

        // Bad select on the 3-channel instance
        load = 1'b1; sel = 2'd1;
        step();
        check("t4.b_out_before", int'(out_b), 2222);
        check("t4.b_ch_before", int'(ch_b), 1);
        sel = 2'd3;
        step();
        check("t4.b_sel_err", int'(err_b), 1);
        check("t4.b_out_held", int'(out_b), 2222);
        check("t4.b_ch_held", int'(ch_b), 1);
        check("t4.b_valid", int'(val_b), 0);
        load = 1'b0;
        step();
        check("t4.b_sel_err_pulse", int'(err_b), 0);

        // Scan wrap from cur_ch=0
        set_a(0, 235); set_a(1, 7224); set_a(2, 275); set_a(3, 3865);
        load = 1'b1; sel = 2'd0;
        step();
        check("t3.start", int'(out_a), 235);
        load = 1'b0; mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("t3.valid%0d", k), int'(val_a), (k % 4 == 0) ? 1 : 0);
            check($sformatf("t3.out%0d", k), int'(out_a), t3_exp[k / 4]);
        end

        // Drop to manual mid-dwell with a simultaneous load, then rescan
        set_a(2, 8254);
        step(); step();
        mode = 1'b0; load = 1'b1; sel = 2'd2;
        step();
        check("t5.out", int'(out_a), 8254);
        check("t5.cur_ch", int'(ch_a), 2);
        check("t5.valid", int'(val_a), 1);
        load = 1'b0; mode = 1'b1;
        step();
        check("t5.rescan_out", int'(out_a), 3865);
        check("t5.rescan_valid", int'(val_a), 1);
        for (int j = 1; j < 4; j++) begin
            step();
            check($sformatf("t5.dwell%0d", j), int'(val_a), 0);
        end
        step();
        check("t5.next_valid", int'(val_a), 1);
        check("t5.next_out", int'(out_a), 235);

        // Reset in the middle of a scan
        rst = 1'b1;
        step();
        check("t1.out", int'(out_a), 0);
        check("t1.cur_ch", int'(ch_a), 0);
        check("t1.valid", int'(val_a), 0);
        step();
        check("t1.out2", int'(out_a), 0);
        rst = 1'b0;
        step();
        check("t1.resume_out", int'(out_a), 7224);
        check("t1.resume_ch", int'(ch_a), 1);

`ifdef MUX_PARITY_EN
        mode = 1'b0; load = 1'b1;
        set_a(0, 30); sel = 2'd0;
        step();
        check("t6.par30", int'(par_a), 0);
        set_a(1, 2485); sel = 2'd1;
        step();
        check("t6.par2485", int'(par_a), 1);
        load = 1'b0;
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            load = ($urandom_range(0, 2) == 0);
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus_a = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) bus_b = {16'($urandom), $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
